// File: rtl/audio_pkg.sv
// Shared audio types: sample width, sample type and the filter FSM states.
package audio_pkg;

  localparam int AUDIO_W = 24;

  typedef logic signed [AUDIO_W-1:0] sample_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } filt_state_t;

endpackage

// File: rtl/filter_fifo.sv
// N-entry circular history buffer.
// The entry at the write pointer is the oldest sample and is read before it is overwritten.
module filter_fifo #(
  parameter int DATA_W = 24,
  parameter int LOG2N  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic signed [DATA_W-1:0] wr_data,
  output logic signed [DATA_W-1:0] oldest
);

  localparam int N = 2 ** LOG2N;

  logic signed [DATA_W-1:0] mem [N];
  logic [LOG2N-1:0]         ptr_q, ptr_d;

  // NOTE: the storage array has no reset, so it can map onto block RAM.
  // Stale contents after reset or flush are masked by the FILL state in the parent.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr_q] <= wr_data;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (clear)      ptr_d = '0;
    else if (wr_en) ptr_d = ptr_q + LOG2N'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  // The read returns the pre-write value, so an overwrite in the same cycle still sees x[n-N].
  assign oldest = mem[ptr_q];

endmodule

// File: rtl/noise_filter.sv
// N-tap boxcar moving-average filter for one audio channel.
// It advances one sample per en strobe, and its registered output holds between strobes.
module noise_filter
  import audio_pkg::*;
#(
  parameter int DATA_W = AUDIO_W,
  parameter int LOG2N  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     flush,
  input  logic signed [DATA_W-1:0] data_in,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     out_valid,
  output logic                     primed
);

  localparam int               ACC_W     = DATA_W + LOG2N;
  localparam logic [LOG2N-1:0] FILL_LAST = LOG2N'((2 ** LOG2N) - 1);

  filt_state_t              state_q, state_d;
  logic [LOG2N-1:0]         fill_q, fill_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] dout_q, dout_d;
  logic                     valid_q, valid_d;

  logic signed [DATA_W-1:0] oldest_raw, oldest;
  logic signed [ACC_W-1:0]  in_ext, old_ext, acc_next;
  logic                     wr_en;

  // A flush in the same cycle discards the incoming sample.
  assign wr_en = en & ~flush;

  filter_fifo #(
    .DATA_W (DATA_W),
    .LOG2N  (LOG2N)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .wr_en   (wr_en),
    .wr_data (data_in),
    .oldest  (oldest_raw)
  );

  // While filling, the window is treated as zero-padded, whatever the RAM holds.
  assign oldest   = (state_q == RUN) ? oldest_raw : '0;
  assign in_ext   = ACC_W'(data_in);
  assign old_ext  = ACC_W'(oldest);
  assign acc_next = acc_q + in_ext - old_ext;

  // NOTE: combinational logic uses blocking assignments. Every output gets a default
  // first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    if (flush) begin
      state_d = FILL;
      fill_d  = '0;
      acc_d   = '0;
      dout_d  = '0;
    end else if (en) begin
      acc_d   = acc_next;
      dout_d  = DATA_W'(acc_next >>> LOG2N);
      valid_d = 1'b1;
      if (state_q == FILL) begin
        fill_d = fill_q + LOG2N'(1);
        if (fill_q == FILL_LAST) state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      fill_q  <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = dout_q;
  assign out_valid = valid_q;
  assign primed    = (state_q == RUN);

endmodule

// File: tb/tb_noise_filter.sv
// Self-checking bench for noise_filter (N=8).
// The reference model averages the last N samples since reset or flush, treating missing samples as zero.
module tb_noise_filter;
  import audio_pkg::*;

  localparam int N = 8;

  logic    clk = 1'b0;
  logic    reset;
  logic    en;
  logic    flush;
  sample_t data_in;
  sample_t data_out;
  logic    out_valid;
  logic    primed;

  int checks   = 0;
  int failures = 0;

  longint  hist[$];
  int      seen;
  sample_t exp_out;
  logic    exp_valid;
  logic    exp_primed;

  always #5 clk = ~clk;

  noise_filter #(.DATA_W(24), .LOG2N(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .primed    (primed)
  );

  // Floor of the mean over an N-wide window.
  function automatic longint model_avg();
    longint s;
    longint q;
    s = 0;
    foreach (hist[i]) s += hist[i];
    q = s / N;
    if (s < 0 && (s % N) != 0) q -= 1;
    return q;
  endfunction

  task automatic model_clear();
    hist.delete();
    seen       = 0;
    exp_out    = '0;
    exp_valid  = 1'b0;
    exp_primed = 1'b0;
  endtask

  // Drive one clock cycle starting at a negedge. Outputs are sampled at the following negedge.
  task automatic cycle(input logic e, input logic f, input sample_t x);
    data_in = x;
    en      = e;
    flush   = f;
    @(negedge clk);
    if (f) begin
      hist.delete();
      seen      = 0;
      exp_out   = '0;
      exp_valid = 1'b0;
    end else if (e) begin
      hist.push_back(longint'(x));
      if (hist.size() > N) void'(hist.pop_front());
      seen++;
      exp_out   = 24'(model_avg());
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    exp_primed = (seen >= N);
    en    = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    en      = 1'b0;
    flush   = 1'b0;
    data_in = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    en      = 1'b1;
    flush   = 1'b0;
    data_in = 24'sd1234;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (data_out !== 24'sd0 || out_valid !== 1'b0 || primed !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: data_out=%0d out_valid=%b primed=%b, expected 0/0/0", data_out, out_valid, primed);
    end
    en = 1'b0;
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_step();
    int tbl [10] = '{100, 200, 300, 400, 500, 600, 700, 800, 800, 800};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 24'sd800);
      checks++;
      if (data_out !== sample_t'(tbl[i]) || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL step_out[%0d]: data_out=%0d valid=%b, expected %0d valid=1", i, data_out, out_valid, tbl[i]);
      end
      checks++;
      if (primed !== (i >= 7)) begin
        failures++;
        $display("FAIL step_primed[%0d]: primed=%b expected %b", i, primed, (i >= 7));
      end
    end
    cycle(1'b0, 1'b0, 24'sd999);
    checks++;
    if (out_valid !== 1'b0 || data_out !== 24'sd800) begin
      failures++;
      $display("FAIL step_hold: data_out=%0d valid=%b, expected 800 valid=0", data_out, out_valid);
    end
  endtask

  task automatic test_negative();
    sample_t x;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      x = (i == 0) ? -24'sd7 : 24'sd0;
      cycle(1'b1, 1'b0, x);
      checks++;
      if (data_out !== ((i < 8) ? -24'sd1 : 24'sd0)) begin
        failures++;
        $display("FAIL neg_floor[%0d]: data_out=%0d expected %0d", i, data_out, (i < 8) ? -1 : 0);
      end
    end
  endtask

  task automatic test_extremes();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, (i < 8) ? 24'sh7FFFFF : 24'sh800000);
      checks++;
      if (data_out !== exp_out) begin
        failures++;
        $display("FAIL extreme[%0d]: data_out=%0d expected %0d", i, data_out, exp_out);
      end
    end
    checks++;
    if (data_out !== -24'sd8388608) begin
      failures++;
      $display("FAIL extreme_final: data_out=%0d expected -8388608", data_out);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 24; k++) begin
      cycle(1'b1, 1'b0, sample_t'(8 * k));
      en = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || data_out !== exp_out) begin
        failures++;
        $display("FAIL ramp[%0d]: data_out=%0d valid=%b, expected %0d valid=1", k, data_out, out_valid, exp_out);
      end
      if (k >= 7) begin
        checks++;
        if (data_out !== sample_t'(8 * k - 28)) begin
          failures++;
          $display("FAIL ramp_mean[%0d]: data_out=%0d expected %0d", k, data_out, 8 * k - 28);
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_flush_collision();
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 24'sd800);
    cycle(1'b1, 1'b1, 24'sd5000);
    checks++;
    if (data_out !== 24'sd0 || primed !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear: data_out=%0d primed=%b valid=%b, expected 0/0/0", data_out, primed, out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 24'sd800);
      checks++;
      if (data_out !== sample_t'(100 * (i + 1))) begin
        failures++;
        $display("FAIL flush_refill[%0d]: data_out=%0d expected %0d", i, data_out, 100 * (i + 1));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 24'sd800);
    data_in = 24'sd800;
    #2 en = 1'b1;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (data_out !== 24'sd0 || out_valid !== 1'b0 || primed !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: data_out=%0d valid=%b primed=%b, expected 0/0/0 before edge", data_out, out_valid, primed);
    end
    @(negedge clk);
    en = 1'b0;
    reset = 1'b1;
    model_clear();
    cycle(1'b1, 1'b0, 24'sd8);
    checks++;
    if (data_out !== 24'sd1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL async_release: data_out=%0d valid=%b, expected 1 valid=1", data_out, out_valid);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0)      cycle(1'($urandom_range(0, 1)), 1'b1, sample_t'($urandom));
      else if (r < 14) cycle(1'b1, 1'b0, sample_t'($urandom));
      else             cycle(1'b0, 1'b0, sample_t'($urandom));
      checks++;
      if (data_out !== exp_out || out_valid !== exp_valid || primed !== exp_primed) begin
        failures++;
        $display("FAIL random[%0d]: out=%0d/valid=%b/primed=%b, expected %0d/%b/%b",
                 i, data_out, out_valid, primed, exp_out, exp_valid, exp_primed);
      end
    end
  endtask

  initial begin
    reset   = 1'b0;
    en      = 1'b0;
    flush   = 1'b0;
    data_in = '0;
    model_clear();
    test_reset();
    test_step();
    test_negative();
    test_extremes();
    test_back_to_back();
    test_flush_collision();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
